// File: rtl/grf_param.sv
// Parameterised register file with byte-lane writes, same-cycle write bypass and
// a pending-producer scoreboard. Define GRF_TRACE_EN to print a line per accepted write.
module grf_param #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RFWr,
    input  logic [DW/8-1:0]   WBE,
    input  logic [AW-1:0]     A3,
    input  logic [DW-1:0]     WData,
    input  logic [31:0]       WPC,
    input  logic [NRD*AW-1:0] RA,
    output logic [NRD*DW-1:0] RD,
    input  logic              Iss,
    input  logic [AW-1:0]     IssA,
    output logic [NRD-1:0]    RBusy,
    output logic [AW:0]       PendCnt
);

    localparam int NB = DW / 8;

    logic [DW-1:0]   rf [NREG];
    logic [NREG-1:0] pend;
    logic            wr_en;
    logic            set_en;
    logic            inc;
    logic            dec;
    logic [DW-1:0]   wmerge;

    assign wr_en  = RFWr && (A3 != '0);
    assign set_en = Iss && (IssA != '0);

    // Counter moves only when a pend bit actually flips; a same-address
    // set+clear keeps the bit high, so it must not count as a release.
    assign inc = set_en && !pend[IssA];
    assign dec = wr_en && pend[A3] && !(set_en && (IssA == A3));

    always_comb begin
        wmerge = rf[A3];
        for (int unsigned b = 0; b < NB; b++) begin
            if (WBE[b]) wmerge[b*8 +: 8] = WData[b*8 +: 8];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[A3] <= wmerge;
`ifdef GRF_TRACE_EN
            $display("%d@%h: $%d <= %h", $time, WPC, A3, wmerge);
`endif
        end
    end

`ifndef GRF_TRACE_EN
    logic unused_wpc;
    assign unused_wpc = ^WPC;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pend    <= '0;
            PendCnt <= '0;
        end else begin
            if (wr_en)  pend[A3]   <= 1'b0;
            if (set_en) pend[IssA] <= 1'b1;
            PendCnt <= PendCnt + (AW+1)'(inc) - (AW+1)'(dec);
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rdv;
        RD    = '0;
        RBusy = '0;
        ra    = '0;
        rdv   = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            ra  = RA[k*AW +: AW];
            rdv = rf[ra];
            if (wr_en && (A3 == ra)) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (WBE[b]) rdv[b*8 +: 8] = WData[b*8 +: 8];
                end
            end
            RD[k*DW +: DW] = rdv;
            RBusy[k]       = pend[ra] && !(wr_en && (A3 == ra));
        end
    end

endmodule

// File: doc/grf_param.md
GRF_PARAM -- requirements
Module: grf_param

Interface
REQ-001 Parameter DW, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter NREG, default 32: register count; SHALL be a power of two, at least 2; AW = clog2(NREG).
REQ-003 Parameter NRD, default 2: number of read ports, range 1..4.
REQ-004 Clk  in  1: sole clock; all state updates on posedge.
REQ-005 Reset  in  1: asynchronous, active-high reset.
REQ-006 RFWr  in  1: write enable.
REQ-007 WBE  in  DW/8: byte-lane write enables; bit i covers WData[8i+7:8i].
REQ-008 A3  in  AW: write address.
REQ-009 WData  in  DW: write data.
REQ-010 WPC  in  32: PC of the writing instruction; used only for the trace.
REQ-011 RA  in  NRD*AW: read addresses; port k uses bits [k*AW+AW-1:k*AW].
REQ-012 RD  out  NRD*DW: read data; packed in the same way as RA.
REQ-013 Iss  in  1: issue strobe; marks register IssA as having a pending producer.
REQ-014 IssA  in  AW: destination address of the issuing instruction.
REQ-015 RBusy  out  NRD: bit k is high when port k's register has a pending, not-yet-written producer.
REQ-016 PendCnt  out  AW+1: number of registers currently pending.

Function
REQ-017 A write SHALL occur on posedge Clk when RFWr=1 and A3!=0; only the lanes enabled in WBE update, and all other lanes hold their value.
REQ-018 Register 0 SHALL always read as 0 and SHALL never become pending; writes and issues to address 0 are ignored.
REQ-019 Read port k SHALL be combinational with zero latency.
REQ-020 When RFWr=1, A3!=0 and A3==RA_k, port k SHALL bypass: enabled lanes come from WData, disabled lanes from the stored value.
REQ-021 The pend[NREG] scoreboard SHALL be updated at posedge Clk:
  - Iss=1 with IssA!=0 sets pend[IssA];
  - RFWr=1 with A3!=0 clears pend[A3], regardless of WBE.
REQ-022 If Iss and RFWr target the same address in one cycle, the set SHALL win and pend stays 1, because a new producer replaces the old one.
REQ-023 RBusy[k] SHALL equal pend[RA_k] AND NOT (RFWr AND A3==RA_k AND A3!=0); a same-cycle write releases the stall through the bypass.
REQ-024 Iss to an address that is already pending SHALL leave it pending and SHALL NOT change PendCnt.
REQ-025 RFWr to an address that is not pending SHALL NOT change PendCnt.
REQ-026 PendCnt SHALL be a registered population count of pend, consistent with pend after every edge.
REQ-027 PendCnt SHALL change by at most +1 or -1 per cycle; a simultaneous set and clear on different addresses leaves it unchanged.
REQ-028 RFWr=1 with WBE=0 SHALL leave the data unchanged but SHALL still clear pend[A3].

Reset
REQ-029 Reset=1 SHALL immediately, without waiting for Clk, clear all registers to 0, clear all pend bits and set PendCnt to 0.
REQ-030 While Reset=1, writes and issues SHALL be ignored.
REQ-031 The RD bypass SHALL follow the inputs combinationally during reset; the stored value is 0.
REQ-032 A reset asserted mid-stream SHALL discard all pending state; no write is retained from the edge at which Reset is sampled high.

Configuration
REQ-033 The macro GRF_TRACE_EN selects the write trace.
REQ-034 With GRF_TRACE_EN defined, each accepted write (REQ-017) SHALL print "%d@%h: $%d <= %h" with $time, WPC, A3 and the merged post-write value.
REQ-035 Without GRF_TRACE_EN, the block SHALL contain no $display, and its behaviour is otherwise identical.

Verification
REQ-036 Pulse Reset asynchronously between edges after arbitrary writes -> all RD=0, PendCnt=0 and RBusy=0 before the next posedge.
REQ-037 Write A3=5, WData=32'hDEADBEEF, WBE=4'b0101 over the stored value 32'h11223344; read RA0=5 in the same cycle -> RD0=32'h11AD33EF both via bypass and on the following cycle.
REQ-038 Iss with IssA=7, then RA1=7 on the following cycles -> RBusy[1]=1 and PendCnt=1; a write to 7 then gives RBusy[1]=0 in the write cycle and PendCnt=0 after the edge.
REQ-039 Same-cycle Iss IssA=9 and RFWr A3=9 with pend[9]=1 -> pend[9] stays 1 and PendCnt unchanged; same-cycle Iss 3 and RFWr 4 with pend[4]=1 -> PendCnt unchanged, pend[3]=1, pend[4]=0.
REQ-040 Write and Iss targeting address 0, with RA0=0 -> RD0=0, RBusy[0]=0, PendCnt=0, and no trace line is printed.
REQ-041 Run with DW=64, NREG=16, NRD=4 and GRF_TRACE_EN both defined and undefined -> identical RD/RBusy/PendCnt traces, and trace lines appear only when the macro is defined.
